// File: rtl/core_run_ctrl_pkg.sv
// Shared state encoding and default widths for the rvmyth run controller.
// Pure definitions, no logic.
package core_ctrl_pkg;

    localparam int ST_W      = 3;
    localparam int CNT_W_DEF = 4;
    localparam int CYC_W_DEF = 8;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/core_run_ctrl_rst_hold_timer.sv
// Reset-hold down-counter: load sets HOLD_CYC-1, decrement stops at zero.
// Latency: zero_o is registered state; no backpressure (always accepts load/dec).
module rst_hold_timer #(
    parameter int HOLD_CYC = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int W = $clog2(HOLD_CYC) + 1;
    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// Run/sequence controller for the rvmyth counter core; optional STEP_EN adds single-step in PAUSE.
// Latency: core_en is combinational on stop/pause/match; state, cycles and done are registered. No backpressure.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int CYC_W    = CYC_W_DEF,
    parameter int HOLD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             step,
    input  logic [CYC_W-1:0] run_len,
    input  logic             match_en,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] count,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycles,
    output logic [ST_W-1:0]  state
);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   run_len_q, run_len_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               match_en_q, match_en_d;
    logic               done_q, done_d;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic               accept, match_hit, len_hit, step_rise;

`ifdef STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_rise   = 1'b0;
`endif

    rst_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
        .clk_i   (clk),
        .rst_n_i (rst),
        .load_i  (tmr_load),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    assign match_hit = match_en_q && (count == target_q);

    always_comb begin
        state_d    = state_q;
        run_len_d  = run_len_q;
        match_en_d = match_en_q;
        target_d   = target_q;
        cycles_d   = cycles_q;
        core_rst   = 1'b1;
        core_en    = 1'b0;
        busy       = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        accept     = 1'b0;
        len_hit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                busy    = 1'b1;
                tmr_dec = 1'b1;
                if (stop) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                core_rst = 1'b0;
                busy     = 1'b1;
                core_en  = !stop && !pause && !match_hit;
                len_hit  = (run_len_q != '0) && core_en && ((cycles_q + CYC_W'(1)) == run_len_q);
                if (stop || match_hit || len_hit) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                core_rst = 1'b0;
                busy     = 1'b1;
                // A step cycle is treated like a RUN cycle for the terminal checks.
                core_en  = step_rise && !stop && !match_hit;
                len_hit  = (run_len_q != '0) && core_en && ((cycles_q + CYC_W'(1)) == run_len_q);
                if (stop || match_hit || len_hit) begin
                    state_d = S_DONE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                core_rst = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            run_len_d  = run_len;
            match_en_d = match_en;
            target_d   = target;
            cycles_d   = '0;
            tmr_load   = 1'b1;
        end else if (core_en && (cycles_q != '1)) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            run_len_q  <= '0;
            match_en_q <= 1'b0;
            target_q   <= '0;
            cycles_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_len_q  <= run_len_d;
            match_en_q <= match_en_d;
            target_q   <= target_d;
            cycles_q   <= cycles_d;
            done_q     <= done_d;
        end
    end

    assign done   = done_q;
    assign cycles = cycles_q;
    assign state  = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: vector table for the basic runs plus hand sequences
// for pause, stop, reset abort, terminal match and single-step.
module tb_core_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, step, match_en;
    logic [7:0] run_len;
    logic [3:0] target, count;
    logic       core_rst, core_en, busy, done;
    logic [7:0] cycles;
    logic [2:0] state;
    logic [3:0] core_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    core_run_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .step     (step),
        .run_len  (run_len),
        .match_en (match_en),
        .target   (target),
        .count    (count),
        .core_rst (core_rst),
        .core_en  (core_en),
        .busy     (busy),
        .done     (done),
        .cycles   (cycles),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Behavioural rvmyth counter core.
    always @(posedge clk) begin
        if (core_rst)     core_cnt <= 4'd0;
        else if (core_en) core_cnt <= core_cnt + 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, start, stop, pause;
        logic [7:0] run_len;
        logic       match_en;
        logic [3:0] target, count;
        logic [2:0] e_state;
        logic       e_rst, e_en, e_busy, e_done;
        logic [7:0] e_cyc;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t v(input logic r, st, sp, pa, input logic [7:0] len,
                               input logic me, input logic [3:0] tg, cn,
                               input logic [2:0] es, input logic er, ee, eb, ed,
                               input logic [7:0] ec);
        vec_t x;
        x.rst = r; x.start = st; x.stop = sp; x.pause = pa; x.run_len = len;
        x.match_en = me; x.target = tg; x.count = cn;
        x.e_state = es; x.e_rst = er; x.e_en = ee; x.e_busy = eb; x.e_done = ed; x.e_cyc = ec;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        vec_cnt++;
        if (act != exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; step = 0;
        run_len = 8'd0; match_en = 0; target = 4'd0;
    endtask

    initial begin
        int en_n, p_n, ps, bad_en, c0, found;
        logic got_done;

        //         rst st sp pa len   me tg    cn   | st   crst en busy done cyc
        tbl[0]  = v(1, 0, 0, 0, 8'd5, 0, 4'd0, 4'd0, 3'd0, 1, 0, 0, 0, 8'd0);
        tbl[1]  = v(1, 1, 0, 0, 8'd5, 0, 4'd0, 4'd0, 3'd0, 1, 0, 0, 0, 8'd0);
        tbl[2]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[3]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[4]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd0);
        tbl[5]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd1);
        tbl[6]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd2);
        tbl[7]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd3);
        tbl[8]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd4);
        tbl[9]  = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 1, 8'd5);
        tbl[10] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 0, 8'd5);
        tbl[11] = v(1, 1, 0, 0, 8'd1, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 0, 8'd5);
        tbl[12] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[13] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[14] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd2, 0, 1, 1, 0, 8'd0);
        tbl[15] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 1, 8'd1);
        tbl[16] = v(1, 1, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 0, 8'd1);
        tbl[17] = v(1, 0, 1, 0, 8'd0, 0, 4'd0, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[18] = v(1, 0, 0, 0, 8'd0, 0, 4'd0, 4'd0, 3'd4, 0, 0, 0, 1, 8'd0);
        tbl[19] = v(1, 1, 0, 0, 8'd0, 1, 4'd3, 4'd0, 3'd4, 0, 0, 0, 0, 8'd0);
        tbl[20] = v(1, 0, 0, 0, 8'd0, 0, 4'd7, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[21] = v(1, 0, 0, 0, 8'd0, 0, 4'd7, 4'd0, 3'd1, 1, 0, 1, 0, 8'd0);
        tbl[22] = v(1, 0, 0, 0, 8'd0, 0, 4'd7, 4'd0, 3'd2, 0, 1, 1, 0, 8'd0);
        tbl[23] = v(1, 0, 0, 1, 8'd0, 0, 4'd7, 4'd3, 3'd2, 0, 0, 1, 0, 8'd1);
        tbl[24] = v(1, 0, 0, 0, 8'd0, 0, 4'd7, 4'd3, 3'd4, 0, 0, 0, 1, 8'd1);

        idle_inputs();
        rst = 0; count = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_cycles", cycles, 0);

        // Table: run_len=5, run_len=1 from DONE, stop in HOLD, match+pause same cycle.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; pause = tbl[i].pause;
            run_len = tbl[i].run_len; match_en = tbl[i].match_en;
            target = tbl[i].target; count = tbl[i].count;
            #1;
            if ({state, core_rst, core_en, busy, done, cycles} !==
                {tbl[i].e_state, tbl[i].e_rst, tbl[i].e_en, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cyc}) begin
                err_cnt++;
                $display("FAIL vec%0d: got st=%0d rst=%0b en=%0b busy=%0b done=%0b cyc=%0d, expected st=%0d rst=%0b en=%0b busy=%0b done=%0b cyc=%0d",
                         i, state, core_rst, core_en, busy, done, cycles, tbl[i].e_state, tbl[i].e_rst,
                         tbl[i].e_en, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cyc);
            end
            vec_cnt++;
        end
        idle_inputs();

        // Pause for 3 cycles after 4 enabled cycles of a 10-cycle run.
        @(negedge clk); start = 1; run_len = 8'd10; count = core_cnt; #1;
        @(negedge clk); start = 0; run_len = 8'd0;
        en_n = 0; p_n = 0; ps = 0; bad_en = 0; got_done = 0;
        for (int k = 0; k < 60 && !got_done; k++) begin
            @(negedge clk);
            pause = (en_n >= 4 && ps < 3);
            if (pause) ps++;
            count = core_cnt;
            #1;
            if (state == 3'd3) p_n++;
            if (core_en) en_n++;
            if ((pause || state == 3'd3) && core_en) bad_en++;
            if (state == 3'd4) begin
                got_done = 1;
                chk("pause_done_pulse", done, 1);
                chk("pause_cycles", cycles, 10);
            end
        end
        pause = 0;
        chk("pause_reached_done", got_done, 1);
        chk("pause_en_total", en_n, 10);
        chk("pause_state_cycles", p_n, 3);
        chk("pause_en_low", bad_en, 0);
        chk("pause_core_count", core_cnt, 10);

        // Stop mid-RUN at cycle 3, then restart from DONE.
        @(negedge clk); start = 1; count = core_cnt; #1;
        @(negedge clk); start = 0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            count = core_cnt; #1;
            if (state == 3'd2 && cycles == 8'd3) found = 1;
            else @(negedge clk);
        end
        chk("stop_found_c3", found, 1);
        stop = 1; #1;
        chk("stop_en_gated", core_en, 0);
        @(negedge clk); stop = 0; count = core_cnt; #1;
        chk("stop_state", state, 4);
        chk("stop_done", done, 1);
        chk("stop_cycles", cycles, 3);
        @(negedge clk); start = 1; #1;
        @(negedge clk); start = 0; #1;
        chk("restart_state", state, 1);
        chk("restart_cycles", cycles, 0);

        // start during RUN ignored; reset mid-RUN aborts without done.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk); count = core_cnt; #1;
            if (state == 3'd2 && cycles == 8'd2) found = 1;
        end
        chk("ign_found_c2", found, 1);
        start = 1; #1;
        @(negedge clk); start = 0; count = core_cnt; #1;
        chk("ign_start_state", state, 2);
        chk("ign_start_cycles", cycles, 3);
        rst = 0; #1;
        @(negedge clk); rst = 1; #1;
        chk("abort_state", state, 0);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_cycles", cycles, 0);
        chk("abort_done", done, 0);
        @(negedge clk); #1;
        chk("abort_done_next", done, 0);

        // Terminal count match at 9 with free-running length.
        @(negedge clk); start = 1; match_en = 1; target = 4'd9; count = core_cnt; #1;
        @(negedge clk); start = 0; match_en = 0; target = 4'd0;
        en_n = 0; bad_en = 0; got_done = 0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            count = core_cnt; #1;
            if (state == 3'd2 && core_cnt == 4'd9 && core_en) bad_en++;
            if (core_en) en_n++;
            if (state == 3'd4) begin
                got_done = 1;
                chk("match_done_pulse", done, 1);
            end
            @(negedge clk);
        end
        chk("match_reached_done", got_done, 1);
        chk("match_cycles", cycles, 9);
        chk("match_en_cnt", en_n, 9);
        chk("match_en_low", bad_en, 0);
        chk("match_core_count", core_cnt, 9);

        // Single-step behaviour inside PAUSE.
        start = 1; count = core_cnt; #1;
        @(negedge clk); start = 0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk); count = core_cnt; #1;
            if (state == 3'd2 && cycles == 8'd2) found = 1;
        end
        chk("step_found_run", found, 1);
        @(negedge clk); pause = 1; count = core_cnt; #1;
        @(negedge clk); count = core_cnt; #1;
        chk("step_in_pause", state, 3);
        c0 = cycles;
`ifdef STEP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); step = 1; count = core_cnt; #1;
            chk("step_pulse_en", core_en, 1);
            @(negedge clk); step = 0; count = core_cnt; #1;
            chk("step_gap_en", core_en, 0);
        end
        chk("step_cycles3", cycles, c0 + 3);
        chk("step_stay_pause", state, 3);
        en_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); step = 1; count = core_cnt; #1;
            if (core_en) en_n++;
        end
        @(negedge clk); step = 0; count = core_cnt; #1;
        chk("step_held_en", en_n, 1);
        chk("step_held_cycles", cycles, c0 + 4);
`else
        en_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); step = 1; count = core_cnt; #1;
            if (core_en) en_n++;
        end
        @(negedge clk); step = 0; count = core_cnt; #1;
        chk("nostep_en", en_n, 0);
        chk("nostep_cycles", cycles, c0);
`endif
        stop = 1; #1;
        @(negedge clk); stop = 0; pause = 0; #1;
        chk("step_stop_state", state, 4);
        chk("step_stop_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/sequence controller for the rvmyth counter core in VSDBabySoC. Drives the core's reset and a clock-enable qualifier. Sequences the core through a reset-hold, a bounded or free run, pause/resume, and a terminal condition. Reports progress (elapsed cycles, busy, done) for the SoC top and the bench.

Parameters:
CNT_W, 4, width of the core count bus
CYC_W, 8, width of the run-length and elapsed-cycle counters
HOLD_CYC, 2, number of cycles core_rst is held high before a run (must be >= 1)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-low reset of this block
start  in  1  single-cycle run request; honoured only in IDLE or DONE
stop  in  1  abort request; priority over pause and step
pause  in  1  level; while high in RUN, the core is frozen
step  in  1  single-step pulse; used only when STEP_EN is defined
run_len  in  CYC_W  number of enabled core cycles; 0 = free-run until stop or match; sampled on an accepted start
match_en  in  1  enables terminal-count stop; sampled on an accepted start
target  in  CNT_W  count value that ends the run when match_en is set; sampled on an accepted start
count  in  CNT_W  count observed from the core
core_rst  out  1  active-high reset to the core
core_en  out  1  core advance qualifier
busy  out  1  high in HOLD, RUN and PAUSE
done  out  1  one-cycle pulse on entry to DONE
cycles  out  CYC_W  number of enabled core cycles in the current or last run; saturates at all-ones
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (rst==0 at an edge) gives:
  - state=IDLE, core_rst=1, core_en=0, busy=0, done=0, cycles=0.
  - All latched configuration is cleared.
  - Reset asserted mid-run aborts the run on that edge. There is no done pulse.
- States: IDLE=0, HOLD=1, RUN=2, PAUSE=3, DONE=4. Encodings 5-7 recover to IDLE on the next edge.
- IDLE:
  - core_rst=1, core_en=0.
  - start -> HOLD. On the same edge: latch run_len, match_en and target; clear cycles; load the hold timer with HOLD_CYC-1.
- HOLD:
  - core_rst=1, core_en=0.
  - The timer decrements each cycle; at 0 -> RUN. core_rst is therefore high for exactly HOLD_CYC cycles in HOLD.
  - stop -> DONE.
- RUN:
  - core_rst=0. core_en=1 unless stop or pause is asserted this cycle (combinational gating).
  - Each cycle with core_en=1, cycles increments, saturating at all-ones.
  - Terminal conditions:
    - latched run_len!=0 and cycles+1==run_len with core_en=1 -> DONE.
    - match_en latched and count==target -> DONE, with core_en forced 0 that cycle.
  - stop -> DONE.
  - pause (and no stop) -> PAUSE.
- PAUSE:
  - core_rst=0, core_en=0.
  - pause==0 -> RUN.
  - stop -> DONE.
- DONE:
  - core_rst=0, core_en=0, and the core keeps its count.
  - done=1 for the single cycle after entry (registered).
  - start -> HOLD, handled exactly as from IDLE.
  - Otherwise remain in DONE; cycles holds its value.
- Simultaneous events:
  - stop beats pause, step and terminal conditions; the end result is DONE in every case.
  - start outside IDLE/DONE is ignored.
  - A terminal condition and pause in the same cycle: terminal wins.
- run_len=1 gives exactly one core_en cycle. run_len=0 with match_en=0 runs until stop.

Optional Feature:
STEP_EN:
- Defined:
  - In PAUSE, a step pulse asserts core_en for exactly one cycle and increments cycles.
  - Terminal checks apply to that cycle; the state stays PAUSE unless a terminal condition or stop fires.
  - A step held high for multiple cycles gives one enabled cycle per rising edge of step (edge detect inside the block).
- Undefined: step is ignored; PAUSE never enables the core.

Decomposition:
- Package core_ctrl_pkg holds:
  - state localparams (IDLE/HOLD/RUN/PAUSE/DONE) and the 3-bit state width;
  - default CNT_W/CYC_W.
- One sub-module: rst_hold_timer (load/decrement/zero flag, width clog2(HOLD_CYC)+1).
- Saturating cycle counter and FSM stay in the top.

Test Plan:
1. Reset then start with run_len=5, match_en=0 (defaults) -> core_rst high 2 cycles; core_en high exactly 5 consecutive cycles; done pulse 1 cycle; cycles=5; state=DONE.
2. run_len=0, match_en=1, target=4'd9, counter core starting at 0 -> DONE entered when count==9; cycles=9; core_en low in the match cycle.
3. run_len=10, pause high for 3 cycles after cycle 4 -> state PAUSE for 3 cycles, core_en low; total core_en cycles still 10.
4. stop in HOLD and again mid-RUN at cycle 3 -> immediate DONE both times, done pulse, cycles=0 and 3 respectively; start from DONE restarts with cycles cleared.
5. rst low mid-RUN -> next edge: IDLE, core_rst=1, cycles=0, no done pulse; start during RUN is ignored.
6. STEP_EN defined, in PAUSE: three step pulses -> three single core_en cycles, cycles+3; step held 4 cycles -> one enabled cycle.
